// File: rtl/min_max_pkg.sv
// Shared state encoding for the min/max finder: one-hot state vectors plus the
// bit positions of each state, so a decoder can name states from the Q outputs.
package min_max_pkg;

    localparam int ST_W = 7;

    localparam int IDX_INI  = 0;
    localparam int IDX_LOAD = 1;
    localparam int IDX_CMX  = 2;
    localparam int IDX_CMNF = 3;
    localparam int IDX_CMN  = 4;
    localparam int IDX_CMXF = 5;
    localparam int IDX_DONE = 6;

    localparam logic [ST_W-1:0] ST_INI  = 7'b0000001;
    localparam logic [ST_W-1:0] ST_LOAD = 7'b0000010;
    localparam logic [ST_W-1:0] ST_CMX  = 7'b0000100;
    localparam logic [ST_W-1:0] ST_CMNF = 7'b0001000;
    localparam logic [ST_W-1:0] ST_CMN  = 7'b0010000;
    localparam logic [ST_W-1:0] ST_CMXF = 7'b0100000;
    localparam logic [ST_W-1:0] ST_DONE = 7'b1000000;

    typedef enum logic [ST_W-1:0] {
        INI  = ST_INI,
        LOAD = ST_LOAD,
        CMX  = ST_CMX,
        CMNF = ST_CMNF,
        CMN  = ST_CMN,
        CMXF = ST_CMXF,
        DONE = ST_DONE
    } state_t;

    // The array is writable and Start is accepted only while parked.
    function automatic logic is_idle(input state_t s);
        return (s == INI) || (s == DONE);
    endfunction

endpackage

// File: rtl/mm_compare.sv
// Single magnitude comparator shared by all scan states; signed mode is
// handled by flipping the sign bits so one unsigned compare serves both.
module mm_compare #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              signed_mode,
    output logic              gt,
    output logic              lt
);

    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;

    // Offset-binary view: two's-complement ordering equals unsigned ordering
    // once the MSB is inverted.
    assign w_a = {a[DATA_W-1] ^ signed_mode, a[DATA_W-2:0]};
    assign w_b = {b[DATA_W-1] ^ signed_mode, b[DATA_W-2:0]};

    assign gt = (w_a > w_b);
    assign lt = (w_a < w_b);

endmodule

// File: rtl/min_max_finder_param.sv
// DEPTH x DATA_W register file scanned by one time-shared comparator, tracking
// up against Max or down against Min with a forced cross-check on each turn.
module min_max_finder_param
    import min_max_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Signed_mode,
    input  logic              Wr_en,
    input  logic [IDX_W-1:0]  Wr_addr,
    input  logic [DATA_W-1:0] Wr_data,
    output logic [DATA_W-1:0] Max,
    output logic [DATA_W-1:0] Min,
    output logic [IDX_W-1:0]  Max_idx,
    output logic [IDX_W-1:0]  Min_idx,
    output logic              Qi,
    output logic              Ql,
    output logic              Qcmx,
    output logic              Qcmnf,
    output logic              Qcmn,
    output logic              Qcmxf,
    output logic              Qd
);

    // Handshake: Start is a one-cycle request with no ready return; it is
    // accepted on any edge where Qi|Qd is high and ignored otherwise.
    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0]  r_i;
    logic              r_signed;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] r_min;
    logic [IDX_W-1:0]  r_max_idx;
    logic [IDX_W-1:0]  r_min_idx;

    logic              w_idle;
    logic              w_last;
    logic              w_accept;
    logic              w_load;
    logic              w_upd_max;
    logic              w_upd_min;
    logic              w_inc;
    logic              w_gt;
    logic              w_lt;
    logic [DATA_W-1:0] w_elem;
    logic [DATA_W-1:0] w_ref;

    assign w_idle = is_idle(r_state);
    assign w_last = (r_i == IDX_W'(DEPTH - 1));
    assign w_elem = r_mem[r_i];
    assign w_ref  = ((r_state == CMX) || (r_state == CMXF)) ? r_max : r_min;

    mm_compare #(.DATA_W(DATA_W)) u_cmp (
        .a           (w_elem),
        .b           (w_ref),
        .signed_mode (r_signed),
        .gt          (w_gt),
        .lt          (w_lt)
    );

    // Array has no reset so its contents survive a Reset pulse.
    always_ff @(posedge Clk) begin
        if (Wr_en && w_idle) begin
            r_mem[Wr_addr] <= Wr_data;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= INI;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_load    = 1'b0;
        w_upd_max = 1'b0;
        w_upd_min = 1'b0;
        w_inc     = 1'b0;
        case (r_state)
            INI, DONE: begin
                if (Start) begin
                    w_accept = 1'b1;
                    w_next   = LOAD;
                end
            end
            LOAD: begin
                w_load = 1'b1;
                w_next = CMX;
            end
            CMX: begin
                if (w_gt) begin
                    w_upd_max = 1'b1;
                    w_inc     = 1'b1;
                end else if (w_lt) begin
                    w_next = CMNF;
                end else begin
                    w_inc = 1'b1;
                end
                if (w_inc) begin
                    w_next = w_last ? DONE : CMX;
                end
            end
            CMNF: begin
                w_upd_min = w_lt;
                w_inc     = 1'b1;
                w_next    = w_last ? DONE : CMN;
            end
            CMN: begin
                if (w_lt) begin
                    w_upd_min = 1'b1;
                    w_inc     = 1'b1;
                end else if (w_gt) begin
                    w_next = CMXF;
                end else begin
                    w_inc = 1'b1;
                end
                if (w_inc) begin
                    w_next = w_last ? DONE : CMN;
                end
            end
            CMXF: begin
                w_upd_max = w_gt;
                w_inc     = 1'b1;
                w_next    = w_last ? DONE : CMX;
            end
            default: begin
                w_next = INI;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_i       <= '0;
            r_signed  <= 1'b0;
            r_max     <= '0;
            r_min     <= '0;
            r_max_idx <= '0;
            r_min_idx <= '0;
        end else begin
            if (r_state == INI) begin
                r_i <= '0;
            end else if (w_load) begin
                r_i <= IDX_W'(1);
            end else if (w_inc && !w_last) begin
                r_i <= r_i + IDX_W'(1);
            end
            if (w_accept) begin
                r_signed <= Signed_mode;
            end
            if (w_load) begin
                r_max     <= r_mem[0];
                r_min     <= r_mem[0];
                r_max_idx <= '0;
                r_min_idx <= '0;
            end else begin
                if (w_upd_max) begin
                    r_max     <= w_elem;
                    r_max_idx <= r_i;
                end
                if (w_upd_min) begin
                    r_min     <= w_elem;
                    r_min_idx <= r_i;
                end
            end
        end
    end

    assign Max     = r_max;
    assign Min     = r_min;
    assign Max_idx = r_max_idx;
    assign Min_idx = r_min_idx;

    assign Qi    = r_state[IDX_INI];
    assign Ql    = r_state[IDX_LOAD];
    assign Qcmx  = r_state[IDX_CMX];
    assign Qcmnf = r_state[IDX_CMNF];
    assign Qcmn  = r_state[IDX_CMN];
    assign Qcmxf = r_state[IDX_CMXF];
    assign Qd    = r_state[IDX_DONE];

endmodule

// File: tb/tb_min_max_finder_param.sv
// Directed bench for min_max_finder_param: a 16x8 instance for the main
// vectors and a 5x12 instance for the non-power-of-two depth case.
module tb_min_max_finder_param;
    import min_max_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;

    logic        a_start = 1'b0;
    logic        a_signed = 1'b0;
    logic        a_wr_en = 1'b0;
    logic [3:0]  a_wr_addr = '0;
    logic [7:0]  a_wr_data = '0;
    logic [7:0]  a_max, a_min;
    logic [3:0]  a_max_idx, a_min_idx;
    logic        a_qi, a_ql, a_qcmx, a_qcmnf, a_qcmn, a_qcmxf, a_qd;

    logic        b_start = 1'b0;
    logic        b_signed = 1'b0;
    logic        b_wr_en = 1'b0;
    logic [2:0]  b_wr_addr = '0;
    logic [11:0] b_wr_data = '0;
    logic [11:0] b_max, b_min;
    logic [2:0]  b_max_idx, b_min_idx;
    logic        b_qi, b_ql, b_qcmx, b_qcmnf, b_qcmn, b_qcmxf, b_qd;

    int n_checks = 0;
    int n_errors = 0;
    int edges;
    int extra;

    min_max_finder_param #(.DATA_W(8), .DEPTH(16)) u_dut (
        .Clk(Clk), .Reset(Reset), .Start(a_start), .Signed_mode(a_signed),
        .Wr_en(a_wr_en), .Wr_addr(a_wr_addr), .Wr_data(a_wr_data),
        .Max(a_max), .Min(a_min), .Max_idx(a_max_idx), .Min_idx(a_min_idx),
        .Qi(a_qi), .Ql(a_ql), .Qcmx(a_qcmx), .Qcmnf(a_qcmnf), .Qcmn(a_qcmn),
        .Qcmxf(a_qcmxf), .Qd(a_qd)
    );

    min_max_finder_param #(.DATA_W(12), .DEPTH(5)) u_dut12 (
        .Clk(Clk), .Reset(Reset), .Start(b_start), .Signed_mode(b_signed),
        .Wr_en(b_wr_en), .Wr_addr(b_wr_addr), .Wr_data(b_wr_data),
        .Max(b_max), .Min(b_min), .Max_idx(b_max_idx), .Min_idx(b_min_idx),
        .Qi(b_qi), .Ql(b_ql), .Qcmx(b_qcmx), .Qcmnf(b_qcmnf), .Qcmn(b_qcmn),
        .Qcmxf(b_qcmxf), .Qd(b_qd)
    );

    // ---------------- clock ----------------
    always #5 Clk = ~Clk;

    function automatic string state_str(input logic [6:0] q);
        if (q == (7'b1 << IDX_INI))  return "INI";
        if (q == (7'b1 << IDX_LOAD)) return "LOAD";
        if (q == (7'b1 << IDX_CMX))  return "CMX";
        if (q == (7'b1 << IDX_CMNF)) return "CMNF";
        if (q == (7'b1 << IDX_CMN))  return "CMN";
        if (q == (7'b1 << IDX_CMXF)) return "CMXF";
        if (q == (7'b1 << IDX_DONE)) return "DONE";
        return "BAD";
    endfunction

    function automatic logic [6:0] a_q();
        return {a_qd, a_qcmxf, a_qcmn, a_qcmnf, a_qcmx, a_ql, a_qi};
    endfunction

    function automatic logic [6:0] b_q();
        return {b_qd, b_qcmxf, b_qcmn, b_qcmnf, b_qcmx, b_ql, b_qi};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (state A=%s B=%s)",
                     tag, obs, exp, state_str(a_q()), state_str(b_q()));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic a_write(input logic [3:0] addr, input logic [7:0] data);
        @(negedge Clk);
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
        @(posedge Clk); #1;
        a_wr_en = 1'b0;
    endtask

    task automatic b_write(input logic [2:0] addr, input logic [11:0] data);
        @(negedge Clk);
        b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = data;
        @(posedge Clk); #1;
        b_wr_en = 1'b0;
    endtask

    // Returns #1 after the accepting edge k, having checked LOAD is entered.
    task automatic a_start_scan(input logic mode, input string tag);
        @(negedge Clk);
        a_start = 1'b1; a_signed = mode;
        @(posedge Clk); #1;
        a_start = 1'b0;
        check({tag, "_load"}, a_q(), ST_LOAD);
    endtask

    // Counts edges from the current point until Qd is seen (bounded).
    task automatic wait_done(input bit sel_b, input string tag, output int n);
        n = 0;
        do begin
            @(posedge Clk); #1;
            n++;
        end while (!(sel_b ? b_qd : a_qd) && n < 200);
        check({tag, "_qd"}, sel_b ? b_qd : a_qd, 1);
    endtask

    task automatic a_expect(input string tag, input logic [7:0] mx, input logic [3:0] mxi,
                            input logic [7:0] mn, input logic [3:0] mni);
        check({tag, "_max"}, a_max, mx);
        check({tag, "_max_idx"}, a_max_idx, mxi);
        check({tag, "_min"}, a_min, mn);
        check({tag, "_min_idx"}, a_min_idx, mni);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_q", a_q(), ST_INI);
        check("rst_max", a_max, 0);
        check("rst_min", a_min, 0);
        check("rst_idx", {a_max_idx, a_min_idx}, 0);
        check("rst_q12", b_q(), ST_INI);
        @(negedge Clk) Reset = 1'b0;

        // Ascending 73h..82h
        for (int i = 0; i < 16; i++) a_write(4'(i), 8'(8'h73 + i));
        a_start_scan(1'b0, "asc");
        wait_done(1'b0, "asc", edges);
        check("asc_edges", edges, 16);
        a_expect("asc", 8'h82, 4'd15, 8'h73, 4'd0);

        // Descending 82h..73h: one direction change
        for (int i = 0; i < 16; i++) a_write(4'(i), 8'(8'h82 - i));
        a_start_scan(1'b0, "desc");
        wait_done(1'b0, "desc", edges);
        check("desc_edges", edges, 17);
        a_expect("desc", 8'h82, 4'd0, 8'h73, 4'd15);

        // Writes and Start during a scan are ignored
        a_start_scan(1'b0, "poke");
        repeat (2) @(posedge Clk);
        #1;
        a_wr_en = 1'b1; a_wr_addr = 4'd0; a_wr_data = 8'h00; a_start = 1'b1;
        @(posedge Clk); #1;
        a_wr_addr = 4'd15; a_wr_data = 8'hFF;
        @(posedge Clk); #1;
        a_wr_en = 1'b0; a_start = 1'b0;
        wait_done(1'b0, "poke", extra);
        check("poke_edges", extra + 4, 17);
        a_expect("poke", 8'h82, 4'd0, 8'h73, 4'd15);
        a_start_scan(1'b0, "rerun");
        wait_done(1'b0, "rerun", edges);
        check("rerun_edges", edges, 17);
        a_expect("rerun", 8'h82, 4'd0, 8'h73, 4'd15);

        // Async reset while in CMN aborts at once; array survives
        a_start_scan(1'b0, "abort");
        extra = 0;
        while (!a_qcmn && extra < 20) begin
            @(posedge Clk); #1;
            extra++;
        end
        check("abort_reach_cmn", a_qcmn, 1);
        #2 Reset = 1'b1;
        #1;
        check("abort_q", a_q(), ST_INI);
        a_expect("abort", 8'h00, 4'd0, 8'h00, 4'd0);
        @(negedge Clk) Reset = 1'b0;
        a_start_scan(1'b0, "post_rst");
        wait_done(1'b0, "post_rst", edges);
        check("post_rst_edges", edges, 17);
        a_expect("post_rst", 8'h82, 4'd0, 8'h73, 4'd15);

        // All equal, then M[7]=5Bh written on the same edge as Start from DONE
        for (int i = 0; i < 16; i++) a_write(4'(i), 8'h5A);
        a_start_scan(1'b0, "eq");
        wait_done(1'b0, "eq", edges);
        check("eq_edges", edges, 16);
        a_expect("eq", 8'h5A, 4'd0, 8'h5A, 4'd0);
        @(negedge Clk);
        a_wr_en = 1'b1; a_wr_addr = 4'd7; a_wr_data = 8'h5B; a_start = 1'b1;
        @(posedge Clk); #1;
        a_wr_en = 1'b0; a_start = 1'b0;
        check("eq2_load", a_q(), ST_LOAD);
        wait_done(1'b0, "eq2", edges);
        check("eq2_edges", edges, 17);
        a_expect("eq2", 8'h5B, 4'd7, 8'h5A, 4'd0);

        // Signed vs unsigned on the same data
        for (int i = 0; i < 16; i++) a_write(4'(i), 8'h10);
        a_write(4'd0, 8'h7F);
        a_write(4'd3, 8'h80);
        a_start_scan(1'b1, "sgn");
        wait_done(1'b0, "sgn", edges);
        a_expect("sgn", 8'h7F, 4'd0, 8'h80, 4'd3);
        a_start_scan(1'b0, "uns");
        wait_done(1'b0, "uns", edges);
        a_expect("uns", 8'h80, 4'd3, 8'h10, 4'd1);

        // 5 x 12-bit instance
        b_write(3'd0, 12'h100);
        b_write(3'd1, 12'hFFF);
        b_write(3'd2, 12'h001);
        b_write(3'd3, 12'hFFF);
        b_write(3'd4, 12'h001);
        @(negedge Clk);
        b_start = 1'b1; b_signed = 1'b0;
        @(posedge Clk); #1;
        b_start = 1'b0;
        check("w12_load", b_q(), ST_LOAD);
        wait_done(1'b1, "w12", edges);
        check("w12_edges", edges, 8);
        check("w12_max", b_max, 12'hFFF);
        check("w12_max_idx", b_max_idx, 3'd1);
        check("w12_min", b_min, 12'h001);
        check("w12_min_idx", b_min_idx, 3'd2);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
